ser_tx: RTL



---
 rtl/ser_pkg.sv | 19 +
 rtl/ser_tx_cnt.sv | 30 +++
 rtl/ser_tx.sv | 110 +++++++++++
 3 files changed

// File: rtl/ser_pkg.sv
// Shared definitions for the serial register link (transmitter and future receiver).
package ser_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    // Bits needed to hold values 0..n-1; at least 1 so a counter is never zero-width.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ser_tx_cnt.sv
// Loadable bit down-counter for ser_tx; last_c flags the final bit of a frame.
module ser_tx_cnt
    import ser_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     load,
    input  logic                     dec,
    output logic [clog2(WIDTH)-1:0]  cnt,
    output logic                     last_c
);

    localparam int unsigned CW = clog2(WIDTH);

    // Decrement stops at zero; the FSM reloads or leaves SHIFT from there.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(WIDTH - 1);
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign last_c = (cnt == '0);

endmodule

// File: rtl/ser_tx.sv
// Parallel-in/serial-out transmitter: accepts a word on valid/ready, shifts it out one bit per clock.
module ser_tx
    import ser_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             sdo_o,
    output logic             sframe_o,
    output logic             done_o,
    output logic             busy_o
);

    localparam int unsigned CW = clog2(WIDTH);

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             sdo_d, sframe_d, done_d, busy_d;
    logic [CW-1:0]    cnt;
    logic             last_c;
    logic             load, dec, accept;

    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    ser_tx_cnt #(.WIDTH(WIDTH)) u_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load   (load),
        .dec    (dec),
        .cnt    (cnt),
        .last_c (last_c)
    );

    // Counter is zero in IDLE, so last_c alone covers the back-to-back accept window.
    assign ready_o = (state_q == IDLE) || last_c;
    assign accept  = valid_i && ready_o;

    // The shift register holds the bits still to come; the head bit is registered onto sdo_o.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        sdo_d    = 1'b0;
        sframe_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        load     = 1'b0;
        dec      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    load     = 1'b1;
                    state_d  = SHIFT;
                    shreg_d  = shift(d_i);
                    sdo_d    = head(d_i);
                    sframe_d = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            SHIFT: begin
                if (!last_c) begin
                    dec      = 1'b1;
                    shreg_d  = shift(shreg_q);
                    sdo_d    = head(shreg_q);
                    sframe_d = 1'b1;
                    busy_d   = 1'b1;
                    done_d   = (cnt == CW'(1));
                end else if (valid_i) begin
                    load     = 1'b1;
                    shreg_d  = shift(d_i);
                    sdo_d    = head(d_i);
                    sframe_d = 1'b1;
                    busy_d   = 1'b1;
                end else begin
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            sdo_o    <= 1'b0;
            sframe_o <= 1'b0;
            done_o   <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            sdo_o    <= sdo_d;
            sframe_o <= sframe_d;
            done_o   <= done_d;
            busy_o   <= busy_d;
        end
    end

endmodule
